// File: rtl/fc_mac_accum_pkg.sv
// Shared definitions for the fully-connected MAC accumulator and the
// downstream quantizer: mode encodings, default neuron lengths, datapath
// widths and the accumulator FSM state type.
package fc_mac_accum_pkg;

    // Layer mode encodings as carried on fc_state / acc_fc_state
    localparam logic FC1_STATE = 1'b0;
    localparam logic FC2_STATE = 1'b1;

    // Default number of MAC beats per output neuron
    localparam int FC1_LEN_DEFAULT = 400;
    localparam int FC2_LEN_DEFAULT = 120;

    // Output (post-saturation) and internal accumulator widths
    localparam int ACC_OUT_W = 23;
    localparam int ACC_INT_W = 26;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_BIAS,
        ST_DONE
    } mac_state_t;

endpackage

// File: rtl/fc_sat23.sv
// Combinational signed saturator from the internal accumulator width down to
// the output width.
// Ports:
//   din  - signed ACC_INT_W-bit value
//   dout - din clamped to the signed ACC_OUT_W-bit range
module fc_sat23
    import fc_mac_accum_pkg::*;
(
    input  logic signed [ACC_INT_W-1:0] din,
    output logic signed [ACC_OUT_W-1:0] dout
);

    localparam logic signed [ACC_INT_W-1:0] SAT_MAX =
        ACC_INT_W'((64'sd1 <<< (ACC_OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_INT_W-1:0] SAT_MIN =
        ACC_INT_W'(-(64'sd1 <<< (ACC_OUT_W - 1)));

    always_comb begin
        dout = din[ACC_OUT_W-1:0];
        if (din > SAT_MAX) begin
            dout = SAT_MAX[ACC_OUT_W-1:0];
        end else if (din < SAT_MIN) begin
            dout = SAT_MIN[ACC_OUT_W-1:0];
        end
    end

endmodule

// File: rtl/fc_mac_accum.sv
// Per-neuron multiply-accumulate for the FC1/FC2 layers. A start pulse
// latches mode and bias, then LEN activation/weight beats are accumulated,
// the bias is added, the sum is saturated to 23 bits and presented with a
// one-cycle acc_valid pulse.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   start             - begin one neuron (accepted only when idle)
//   fc_state, bias    - neuron mode and pre-scaled bias, latched on start
//   in_valid/in_ready - act/wgt handshake, ready only while accumulating
//   act, wgt          - signed 8-bit operands
//   acc_valid         - one-cycle result strobe
//   acc_data          - biased, saturated neuron sum (held until next result)
//   acc_fc_state      - mode of the neuron on acc_data
//   busy              - high whenever not idle
module fc_mac_accum
    import fc_mac_accum_pkg::*;
#(
    parameter int FC1_LEN = FC1_LEN_DEFAULT,
    parameter int FC2_LEN = FC2_LEN_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        fc_state,
    input  logic signed [15:0]          bias,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [7:0]           act,
    input  logic signed [7:0]           wgt,
    output logic                        acc_valid,
    output logic signed [ACC_OUT_W-1:0] acc_data,
    output logic                        acc_fc_state,
    output logic                        busy
);

    localparam int MAX_LEN = (FC1_LEN > FC2_LEN) ? FC1_LEN : FC2_LEN;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_FC1 = CNT_W'(FC1_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_FC2 = CNT_W'(FC2_LEN - 1);

    mac_state_t state_q, state_d;

    logic signed [ACC_INT_W-1:0] acc_q;
    logic        [CNT_W-1:0]     cnt_q;
    logic                        mode_q;
    logic signed [15:0]          bias_q;

    logic                        beat;
    logic                        last_beat;
    logic signed [15:0]          prod;
    logic signed [ACC_INT_W-1:0] prod_ext;
    logic signed [ACC_INT_W-1:0] bias_ext;
    logic signed [ACC_INT_W-1:0] biased;
    logic signed [ACC_OUT_W-1:0] sat_out;

    assign beat      = in_valid && (state_q == ST_ACC);
    assign last_beat = beat && (cnt_q == ((mode_q == FC2_STATE) ? LAST_FC2 : LAST_FC1));

    assign prod     = act * wgt;
    assign prod_ext = {{(ACC_INT_W - 16){prod[15]}}, prod};
    assign bias_ext = {{(ACC_INT_W - 16){bias_q[15]}}, bias_q};
    assign biased   = acc_q + bias_ext;

    fc_sat23 u_sat (
        .din  (biased),
        .dout (sat_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_ACC;
            ST_ACC:  if (last_beat) state_d = ST_BIAS;
            ST_BIAS: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            mode_q       <= FC1_STATE;
            bias_q       <= '0;
            acc_data     <= '0;
            acc_fc_state <= FC1_STATE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_q  <= '0;
                        cnt_q  <= '0;
                        mode_q <= fc_state;
                        bias_q <= bias;
                    end
                end
                ST_ACC: begin
                    if (beat) begin
                        acc_q <= acc_q + prod_ext;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_BIAS: begin
                    // Mode is copied alongside the data so it stays valid
                    // even after the next start relatches mode_q.
                    acc_data     <= sat_out;
                    acc_fc_state <= mode_q;
                end
                default: ;
            endcase
        end
    end

    assign acc_valid = (state_q == ST_DONE);
    assign in_ready  = (state_q == ST_ACC);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fc_mac_accum.sv
// Self-checking bench for fc_mac_accum: directed table of neurons, random
// neurons against a sum-of-products reference, reset abort and back-to-back
// start sequences.
module tb_fc_mac_accum;
    import fc_mac_accum_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               fc_state;
    logic signed [15:0] bias;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  act;
    logic signed [7:0]  wgt;
    logic               acc_valid;
    logic signed [22:0] acc_data;
    logic               acc_fc_state;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_valid = 0;

    fc_mac_accum #(.FC1_LEN(400), .FC2_LEN(120)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .fc_state     (fc_state),
        .bias         (bias),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .act          (act),
        .wgt          (wgt),
        .acc_valid    (acc_valid),
        .acc_data     (acc_data),
        .acc_fc_state (acc_fc_state),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (acc_valid === 1'b1) n_valid++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic longint clamp23(input longint v);
        if (v > 4194303) return 4194303;
        if (v < -4194304) return -4194304;
        return v;
    endfunction

    // Runs one neuron from idle. Latency is counted from the cycle in which the
    // last beat is presented to the cycle in which acc_valid is seen.
    task automatic run_neuron(input logic mode, input int b, input bit rnd_ops,
                              input int a0, input int w0, input int gap_pct,
                              output longint got, output longint got_fc,
                              output int lat, output longint model);
        int     len = (mode == FC2_STATE) ? 120 : 400;
        int     n = 0;
        int     last_cyc = 0;
        longint sum = 0;
        bit     seen = 0;
        @(posedge clk); #1;
        start = 1'b1; fc_state = mode; bias = 16'(b); in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        // Mode and bias must have been latched; scramble the inputs.
        fc_state = 1'($urandom);
        bias = 16'($urandom);
        for (int c = 0; c < len * 20 && n < len; c++) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            if (rnd_ops) begin
                act = 8'($urandom);
                wgt = 8'($urandom);
            end else begin
                act = 8'(a0);
                wgt = 8'(w0);
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                sum += longint'(act) * longint'(wgt);
                n++;
                last_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("beats_accepted", n, len);
        model = clamp23(sum + longint'(b));
        got = 0; got_fc = -1; lat = -1;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            if (acc_valid) begin
                seen = 1;
                got = acc_data;
                got_fc = acc_fc_state;
                lat = cyc - last_cyc;
            end else begin
                chk("in_ready_low_after_acc", in_ready, 0);
            end
        end
        @(negedge clk);
        chk("acc_valid_one_cycle", acc_valid, 0);
        chk("busy_low_idle", busy, 0);
        chk("in_ready_low_idle", in_ready, 0);
    endtask

    typedef struct {
        logic   mode;
        int     b;
        int     a;
        int     w;
        int     gap;
        longint exp_data;
    } vec_t;

    vec_t   tbl [4];
    longint got, got_fc, model, d1, d2;
    int     lat, v1, v2, nv0;

    initial begin
        tbl[0] = '{1'b1, 5, 1, 2, 0, 245};
        tbl[1] = '{1'b0, 0, 127, 127, 0, 4194303};
        tbl[2] = '{1'b0, -32768, -128, 127, 0, -4194304};
        tbl[3] = '{1'b1, 0, -3, 4, 40, -1440};

        rst = 1'b1; start = 1'b0; fc_state = 1'b0; bias = '0;
        in_valid = 1'b0; act = '0; wgt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_acc_valid", acc_valid, 0);
        chk("rst_acc_data", acc_data, 0);
        chk("rst_acc_fc_state", acc_fc_state, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 4; i++) begin
            run_neuron(tbl[i].mode, tbl[i].b, 1'b0, tbl[i].a, tbl[i].w, tbl[i].gap,
                       got, got_fc, lat, model);
            chk($sformatf("tbl%0d_data", i), got, tbl[i].exp_data);
            chk($sformatf("tbl%0d_fc", i), got_fc, longint'(tbl[i].mode));
            chk($sformatf("tbl%0d_latency", i), lat, 2);
        end

        for (int i = 0; i < 6; i++) begin
            logic m;
            int   b;
            m = 1'($urandom);
            b = int'($signed(16'($urandom)));
            run_neuron(m, b, 1'b1, 0, 0, 25, got, got_fc, lat, model);
            chk($sformatf("rnd%0d_data", i), got, model);
            chk($sformatf("rnd%0d_fc", i), got_fc, longint'(m));
            chk($sformatf("rnd%0d_latency", i), lat, 2);
        end

        // Reset in the middle of an FC1 neuron
        @(posedge clk); #1;
        start = 1'b1; fc_state = FC1_STATE; bias = '0;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; act = 8'sd1; wgt = 8'sd1;
        repeat (50) @(posedge clk);
        #2;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_acc_data", acc_data, 0);
        chk("mid_rst_acc_valid", acc_valid, 0);
        chk("mid_rst_acc_fc_state", acc_fc_state, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        nv0 = n_valid;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_no_pulse", n_valid, nv0);
        chk("post_rst_busy", busy, 0);
        in_valid = 1'b0;
        run_neuron(FC2_STATE, 0, 1'b0, 1, 1, 0, got, got_fc, lat, model);
        chk("post_rst_data", got, 120);
        chk("post_rst_fc", got_fc, 1);

        // start held high across two FC2 neurons
        @(posedge clk); #1;
        start = 1'b1; fc_state = FC2_STATE; bias = '0;
        in_valid = 1'b1; act = 8'sd1; wgt = 8'sd1;
        v1 = -1; v2 = -1; d1 = 0; d2 = 0;
        for (int c = 0; c < 400 && v2 < 0; c++) begin
            @(negedge clk);
            if (acc_valid) begin
                if (v1 < 0) begin
                    v1 = cyc; d1 = acc_data;
                end else begin
                    v2 = cyc; d2 = acc_data;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        chk("b2b_period", v2 - v1, 123);
        chk("b2b_data1", d1, 120);
        chk("b2b_data2", d2, 120);
        repeat (3) @(negedge clk);
        chk("b2b_idle_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_mac_accum.md
FC_MAC_ACCUM -- requirements
Module: fc_mac_accum

Interface
REQ-001 Parameter FC1_LEN, default 400: number of MAC beats per output neuron in FC1 mode.
REQ-002 Parameter FC2_LEN, default 120: number of MAC beats per output neuron in FC2 mode.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port start  input  1  one-cycle pulse that begins one neuron.
REQ-006 Port fc_state  input  1  0 = FC1, 1 = FC2; sampled on an accepted start.
REQ-007 Port bias  input  16 signed  neuron bias, pre-scaled to accumulator LSB; sampled on an accepted start.
REQ-008 Port in_valid  input  1  activation/weight pair present.
REQ-009 Port in_ready  output  1  block accepts a pair this cycle.
REQ-010 Port act  input  8 signed  quantized activation.
REQ-011 Port wgt  input  8 signed  quantized weight.
REQ-012 Port acc_valid  output  1  one-cycle pulse, acc_data valid.
REQ-013 Port acc_data  output  23 signed  biased, saturated neuron sum for the downstream quantizer.
REQ-014 Port acc_fc_state  output  1  mode of the neuron on acc_data, stable while acc_valid = 1.
REQ-015 Port busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, ACC, BIAS, DONE.
REQ-017 IDLE -> ACC on start = 1; the accumulator and beat counter clear, and fc_state and bias latch.
REQ-018 start is ignored in ACC, BIAS and DONE.
REQ-019 in_ready = 1 only in ACC; a beat occurs when in_valid and in_ready are both 1.
REQ-020 Each beat adds the full-precision 16-bit signed product act*wgt to a 26-bit signed accumulator and increments the counter.
REQ-021 A beat with counter = LEN-1 (LEN from the latched mode) moves ACC -> BIAS.
REQ-022 BIAS: the block adds the sign-extended bias to the accumulator, then clamps to the 23-bit range: above 4194303 gives 4194303; below -4194304 gives -4194304.
REQ-023 The clamped value registers into acc_data, and the state moves BIAS -> DONE.
REQ-024 DONE: acc_valid = 1 for exactly one cycle, acc_fc_state = latched mode, then DONE -> IDLE.
REQ-025 Latency: acc_valid rises 2 cycles after the clock edge that accepts the last beat.
REQ-026 acc_data holds its value until the next DONE.
REQ-027 There is no output back-pressure; the downstream stage samples acc_data on the acc_valid cycle.
REQ-028 When in_valid = 0 in ACC, the block stalls: the accumulator and counter hold.
REQ-029 The counter width is ceil(log2(max(FC1_LEN, FC2_LEN))) bits.
REQ-030 Back-to-back operation: a start asserted in the cycle after DONE (IDLE) is accepted; the minimum neuron period is LEN+3 cycles.

Reset
REQ-031 While rst = 1: state = IDLE, accumulator = 0, counter = 0, acc_data = 0, acc_valid = 0, acc_fc_state = 0, in_ready = 0, busy = 0.
REQ-032 Reset asserted mid-neuron aborts the neuron with no acc_valid pulse; a new start is required after release.
REQ-033 Reset release is not observed until the first clk edge after rst falls.

Structure
REQ-034 A shared package holds the FC1_STATE/FC2_STATE mode encodings, FC1_LEN/FC2_LEN defaults, ACC_OUT_W = 23 and ACC_INT_W = 26; the downstream quantizer uses the same package.
REQ-035 One sub-module is natural: fc_sat23, a combinational 26-to-23-bit signed saturator.
REQ-036 The FSM, counter and accumulator stay in fc_mac_accum.

Verification
REQ-037 FC2 mode, bias = 5, 120 beats of act = 1, wgt = 2 -> one acc_valid with acc_data = 245, acc_fc_state = 1, 2 cycles after the last beat.
REQ-038 FC1 mode, bias = 0, 400 beats of act = 127, wgt = 127 (sum 6451600) -> acc_data = 4194303 (positive clamp).
REQ-039 FC1 mode, bias = -32768, 400 beats of act = -128, wgt = 127 -> acc_data = -4194304 (negative clamp).
REQ-040 FC2 mode, in_valid toggled with random gaps over 120 beats of act = -3, wgt = 4, bias = 0 -> acc_data = -1440; in_ready = 0 outside ACC.
REQ-041 rst pulsed at beat 50 of FC1 -> all outputs 0 immediately, no acc_valid; a following FC2 neuron with act = 1, wgt = 1, bias = 0 -> acc_data = 120.
REQ-042 start held high across two back-to-back FC2 neurons -> the second start is accepted only in IDLE; two acc_valid pulses occur 123 cycles apart.
